// File: rtl/dffram_pkg.sv
// -----------------------------------------------------------------------------
// dffram_pkg
// Shared definitions for the byte-writable DFFRAM wrapper:
//   - controller state encoding (ST_CLEAR, ST_RUN)
//   - lane-count helper (one write-enable lane per byte of the data word)
//   - elaboration-time parameter legality checks used by the top level
// -----------------------------------------------------------------------------
package dffram_pkg;

  // Controller states: sweep the array to zero, then serve requests.
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } dffram_state_e;

  // Number of byte lanes in a data word.
  function automatic int lane_count(input int data_length);
    return data_length / 8;
  endfunction

  // Word width must be a non-zero multiple of 8 so every lane is a full byte.
  function automatic bit width_ok(input int data_length);
    return (data_length > 0) && ((data_length % 8) == 0);
  endfunction

  // Depth must be at least one word and fit in the address space.
  function automatic bit depth_ok(input int address_length, input int depth);
    longint unsigned span;
    span = 64'd1 << address_length;
    return (depth >= 1) && (longint'(depth) <= span);
  endfunction

  // Only one or two register stages on the read path are supported.
  function automatic bit latency_ok(input int read_latency);
    return (read_latency == 1) || (read_latency == 2);
  endfunction

endpackage

// File: rtl/dffram_bw_array.sv
// -----------------------------------------------------------------------------
// dffram_bw_array
// Behavioural storage array with per-byte-lane write and a registered read
// port. No reset: contents and the read register are only ever changed by
// writes/reads. Out-of-range writes are dropped, out-of-range reads load 0.
//
// Ports:
//   clk      in   clock
//   wr_be    in   byte-lane write enables (all-zero = no write)
//   wr_addr  in   write word address
//   wr_data  in   write data
//   rd_en    in   load the read register this edge
//   rd_addr  in   read word address
//   rd_data  out  registered read data (holds between reads)
// -----------------------------------------------------------------------------
module dffram_bw_array
  import dffram_pkg::*;
#(
  parameter int ADDRESS_LENGTH = 11,
  parameter int DATA_LENGTH    = 32,
  parameter int DEPTH          = 2048,
  localparam int LANES         = lane_count(DATA_LENGTH)
) (
  input  logic                      clk,
  input  logic [LANES-1:0]          wr_be,
  input  logic [ADDRESS_LENGTH-1:0] wr_addr,
  input  logic [DATA_LENGTH-1:0]    wr_data,
  input  logic                      rd_en,
  input  logic [ADDRESS_LENGTH-1:0] rd_addr,
  output logic [DATA_LENGTH-1:0]    rd_data
);

  // Index width just large enough for DEPTH words (at least one bit).
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDRESS_LENGTH:0] DEPTH_W = (ADDRESS_LENGTH + 1)'(DEPTH);

  logic [DATA_LENGTH-1:0] mem_q [DEPTH];
  logic [DATA_LENGTH-1:0] rd_data_q;
  logic                   wr_in_range_s;
  logic                   rd_in_range_s;
  logic [IDX_W-1:0]       wr_idx_s;
  logic [IDX_W-1:0]       rd_idx_s;

  // Range decode and index truncation for both ports.
  always_comb begin
    wr_in_range_s = ({1'b0, wr_addr} < DEPTH_W);
    rd_in_range_s = ({1'b0, rd_addr} < DEPTH_W);
    wr_idx_s      = wr_addr[IDX_W-1:0];
    rd_idx_s      = rd_addr[IDX_W-1:0];
  end

  // Byte-lane write: only enabled lanes of an in-range word change.
  always_ff @(posedge clk) begin
    if (wr_in_range_s) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_be[i]) begin
          mem_q[wr_idx_s][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Registered read port; out-of-range addresses read as zero.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data_q <= rd_in_range_s ? mem_q[rd_idx_s] : '0;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/dffram_rtl_bw.sv
// -----------------------------------------------------------------------------
// dffram_rtl_bw
// Parametrised byte-writable RAM wrapper used as instruction/data memory.
// After reset it optionally sweeps every word to zero (one per cycle), then
// accepts one request per cycle with a READY handshake. Reads return data
// after READ_LATENCY (1 or 2) cycles with a one-cycle DoValid strobe; Do
// holds its last value between reads.
//
// Ports:
//   CLK        in   clock
//   RSTn       in   asynchronous active-low reset
//   EN         in   request valid (accepted when EN && READY at a rising edge)
//   WE         in   byte-lane write enables; all-zero means read
//   A          in   word address
//   Di         in   write data
//   READY      out  request can be accepted this cycle
//   Do         out  read data
//   DoValid    out  Do carries a completed read this cycle
//   INIT_DONE  out  clear sweep finished (sticky until reset)
// -----------------------------------------------------------------------------
module dffram_rtl_bw
  import dffram_pkg::*;
#(
  parameter int ADDRESS_LENGTH = 11,
  parameter int DATA_LENGTH    = 32,
  parameter int DEPTH          = 2048,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1,
  localparam int LANES         = lane_count(DATA_LENGTH)
) (
  input  logic                      CLK,
  input  logic                      RSTn,
  input  logic                      EN,
  input  logic [LANES-1:0]          WE,
  input  logic [ADDRESS_LENGTH-1:0] A,
  input  logic [DATA_LENGTH-1:0]    Di,
  output logic                      READY,
  output logic [DATA_LENGTH-1:0]    Do,
  output logic                      DoValid,
  output logic                      INIT_DONE
);

  // Illegal parameter combinations stop elaboration.
  if (!width_ok(DATA_LENGTH)) begin : g_bad_width
    $error("dffram_rtl_bw: DATA_LENGTH must be a non-zero multiple of 8");
  end
  if (!depth_ok(ADDRESS_LENGTH, DEPTH)) begin : g_bad_depth
    $error("dffram_rtl_bw: DEPTH must be in 1 .. 2**ADDRESS_LENGTH");
  end
  if (!latency_ok(READ_LATENCY)) begin : g_bad_latency
    $error("dffram_rtl_bw: READ_LATENCY must be 1 or 2");
  end

  localparam logic [ADDRESS_LENGTH-1:0] LAST_ADDR = ADDRESS_LENGTH'(DEPTH - 1);

  dffram_state_e             state_d, state_q;
  logic [ADDRESS_LENGTH-1:0] cnt_d, cnt_q;
  logic                      ready_d, ready_q;
  logic                      init_done_d, init_done_q;

  logic                      clr_we_s;
  logic                      accept_s;
  logic                      rd_acc_s;
  logic                      wr_acc_s;

  logic [LANES-1:0]          arr_be_s;
  logic [ADDRESS_LENGTH-1:0] arr_waddr_s;
  logic [DATA_LENGTH-1:0]    arr_wdata_s;
  logic [DATA_LENGTH-1:0]    arr_rdata_s;

  // Handshake decode: requests are only seen while READY is registered high.
  always_comb begin
    accept_s = EN && ready_q;
    rd_acc_s = accept_s && (WE == '0);
    wr_acc_s = accept_s && (WE != '0);
  end

  // Controller next-state: the sweep leaves on the last word so it takes DEPTH edges.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ready_d     = ready_q;
    init_done_d = init_done_q;
    clr_we_s    = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        if (CLEAR_ON_RESET != 0) begin
          clr_we_s = 1'b1;
          if (cnt_q == LAST_ADDR) begin
            state_d     = ST_RUN;
            ready_d     = 1'b1;
            init_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + ADDRESS_LENGTH'(1);
          end
        end else begin
          state_d     = ST_RUN;
          ready_d     = 1'b1;
          init_done_d = 1'b1;
        end
      end
      ST_RUN: begin
        ready_d     = 1'b1;
        init_done_d = 1'b1;
      end
      default: begin
        state_d     = ST_CLEAR;
        cnt_d       = '0;
        ready_d     = 1'b0;
        init_done_d = 1'b0;
      end
    endcase
  end

  // Controller registers; reset always restarts the sweep from word 0.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= ST_CLEAR;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      init_done_q <= init_done_d;
    end
  end

  // Write-port mux: the clear sweep owns the port while READY is low.
  always_comb begin
    arr_be_s    = '0;
    arr_waddr_s = A;
    arr_wdata_s = Di;
    if (clr_we_s) begin
      arr_be_s    = '1;
      arr_waddr_s = cnt_q;
      arr_wdata_s = '0;
    end else if (wr_acc_s) begin
      arr_be_s = WE;
    end else begin
      arr_be_s = '0;
    end
  end

  dffram_bw_array #(
    .ADDRESS_LENGTH (ADDRESS_LENGTH),
    .DATA_LENGTH    (DATA_LENGTH),
    .DEPTH          (DEPTH)
  ) u_array (
    .clk     (CLK),
    .wr_be   (arr_be_s),
    .wr_addr (arr_waddr_s),
    .wr_data (arr_wdata_s),
    .rd_en   (rd_acc_s),
    .rd_addr (A),
    .rd_data (arr_rdata_s)
  );

  if (READ_LATENCY == 2) begin : g_lat2
    logic                   rd_v1_d, rd_v1_q;
    logic                   do_valid_d, do_valid_q;
    logic [DATA_LENGTH-1:0] do_data_d, do_data_q;

    // Second read stage: copy the array register one cycle after the accept.
    always_comb begin
      rd_v1_d    = rd_acc_s;
      do_valid_d = rd_v1_q;
      if (rd_v1_q) begin
        do_data_d = arr_rdata_s;
      end else begin
        do_data_d = do_data_q;
      end
    end

    // Pipeline registers; reset drops any read still in flight.
    always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
        rd_v1_q    <= 1'b0;
        do_valid_q <= 1'b0;
        do_data_q  <= '0;
      end else begin
        rd_v1_q    <= rd_v1_d;
        do_valid_q <= do_valid_d;
        do_data_q  <= do_data_d;
      end
    end

    assign Do      = do_data_q;
    assign DoValid = do_valid_q;
  end else begin : g_lat1
    logic do_valid_d, do_valid_q;
    logic do_seen_d, do_seen_q;

    // The array register is the output stage; do_seen masks its unreset
    // contents so Do reads zero until the first read after reset.
    always_comb begin
      do_valid_d = rd_acc_s;
      if (rd_acc_s) begin
        do_seen_d = 1'b1;
      end else begin
        do_seen_d = do_seen_q;
      end
    end

    // Strobe and first-read flag registers.
    always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
        do_valid_q <= 1'b0;
        do_seen_q  <= 1'b0;
      end else begin
        do_valid_q <= do_valid_d;
        do_seen_q  <= do_seen_d;
      end
    end

    assign Do      = do_seen_q ? arr_rdata_s : '0;
    assign DoValid = do_valid_q;
  end

  assign READY     = ready_q;
  assign INIT_DONE = init_done_q;

endmodule
